// File: rtl/irrigation_valve_seq.sv
// irrigation_valve_seq
//
// Sequences one irrigation channel at a time through a valve/pump run:
//   IDLE  -> pick a channel (sprinkler > drip > specific), latch it
//   OPEN  -> latched valve open, pump off, for PUMP_DELAY cycles
//   RUN   -> latched valve and pump on, counting pump-on cycles
//   CLOSE -> pump off, latched valve still open, for PUMP_DELAY cycles
//   COOL  -> everything off for COOLDOWN cycles, then back to IDLE
//
// A run ends on an empty tank (checked first, ignores MIN_ON), on reaching
// MAX_ON pump-on cycles (timeout), or when the latched request drops after
// at least MIN_ON pump-on cycles.
//
// Optional feature macro: IRRIGATION_VALVE_SEQ_TIMEOUT_EN
//   defined   : MAX_ON limit, sticky timeout_alarm and per-channel lockout
//               (a timed-out channel is skipped until its request is seen low)
//   undefined : runs are not limited by MAX_ON, timeout_alarm is tied to 0
//               and there is no lockout
//
// Parameters:
//   PUMP_DELAY  valve-to-pump and pump-to-valve delay in cycles
//   MIN_ON      minimum pump-on cycles per run (unless the tank empties)
//   MAX_ON      maximum pump-on cycles per run
//   COOLDOWN    forced idle cycles after every run
//   CNT_W       width of the shared phase counter
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-high reset
//   sprinkler_req    sprinkler channel demand
//   drip_req         drip channel demand
//   specific_req     specific-zone channel demand
//   water_box[1:0]   tank level, 2'b00 = empty
//   sprinkler_valve  valve drives, at most one high at a time
//   drip_valve
//   specific_valve
//   pump             pump drive, only ever high together with a valve
//   busy             high in every state except IDLE
//   timeout_alarm    sticky flag, set when a run hits MAX_ON
//   state_dbg[2:0]   current FSM state (0 IDLE, 1 OPEN, 2 RUN, 3 CLOSE, 4 COOL)
//
// Handshake note: there is no valid/ready pairing here. Requests are level
// demands sampled only in IDLE (plus the latched one while in RUN); outputs
// are Moore levels decoded from registered state.

module irrigation_valve_seq #(
  parameter int unsigned PUMP_DELAY = 4,
  parameter int unsigned MIN_ON     = 8,
  parameter int unsigned MAX_ON     = 64,
  parameter int unsigned COOLDOWN   = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sprinkler_req,
  input  logic       drip_req,
  input  logic       specific_req,
  input  logic [1:0] water_box,
  output logic       sprinkler_valve,
  output logic       drip_valve,
  output logic       specific_valve,
  output logic       pump,
  output logic       busy,
  output logic       timeout_alarm,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPEN  = 3'd1,
    S_RUN   = 3'd2,
    S_CLOSE = 3'd3,
    S_COOL  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam longint unsigned CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;

  // Elaboration-time guard: the shared counter must be able to hold every
  // timing parameter, otherwise a phase could never complete.
  if (CNT_W >= 32 || longint'(PUMP_DELAY) > CNT_LIMIT ||
      longint'(MIN_ON) > CNT_LIMIT || longint'(MAX_ON) > CNT_LIMIT ||
      longint'(COOLDOWN) > CNT_LIMIT) begin : g_bad_cnt_w
    $error("irrigation_valve_seq: CNT_W too narrow for timing parameters");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Latched channel, one-hot: bit0 sprinkler, bit1 drip, bit2 specific.
  logic [2:0]       chan_q, chan_d;

  logic [2:0]       req_vec;
  logic [2:0]       eligible;
  logic [2:0]       pick;
  logic             tank_empty;
  logic             latched_req;
  logic [31:0]      cnt_plus1;
  logic             delay_done;
  logic             min_met;
  logic             cool_done;
  logic             valve_on;

`ifdef IRRIGATION_VALVE_SEQ_TIMEOUT_EN
  logic [2:0]       lock_q, lock_d;
  logic             alarm_q, alarm_d;
  logic             max_hit;
  logic             timeout_now;
`endif

  assign req_vec     = {specific_req, drip_req, sprinkler_req};
  assign tank_empty  = (water_box == 2'b00);
  assign latched_req = |(chan_q & req_vec);

  // The counter holds "cycles already spent in this state"; cnt_plus1 is the
  // count including the current cycle, so a phase of length N ends on the
  // cycle where cnt_plus1 reaches N. A zero-length parameter still costs one
  // cycle in its state.
  assign cnt_plus1  = 32'(cnt_q) + 32'd1;
  assign delay_done = (cnt_plus1 >= PUMP_DELAY);
  assign min_met    = (cnt_plus1 >= MIN_ON);
  assign cool_done  = (cnt_plus1 >= COOLDOWN);

`ifdef IRRIGATION_VALVE_SEQ_TIMEOUT_EN
  assign max_hit  = (cnt_plus1 >= MAX_ON);
  assign eligible = req_vec & ~lock_q;
`else
  assign eligible = req_vec;
`endif

  // Fixed-priority pick among eligible channels.
  always_comb begin
    pick = 3'b000;
    if (eligible[0]) begin
      pick = 3'b001;
    end else if (eligible[1]) begin
      pick = 3'b010;
    end else if (eligible[2]) begin
      pick = 3'b100;
    end
  end

  // Next-state, counter and channel latch.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    // Saturating increment; any state change overrides this with a clear.
    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
`ifdef IRRIGATION_VALVE_SEQ_TIMEOUT_EN
    timeout_now = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!tank_empty && (eligible != 3'b000)) begin
          chan_d  = pick;
          state_d = S_OPEN;
        end
      end

      S_OPEN: begin
        if (delay_done) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        // Empty tank wins over everything, including MIN_ON.
        if (tank_empty) begin
          state_d = S_CLOSE;
          cnt_d   = '0;
`ifdef IRRIGATION_VALVE_SEQ_TIMEOUT_EN
        end else if (max_hit) begin
          state_d     = S_CLOSE;
          cnt_d       = '0;
          timeout_now = 1'b1;
`endif
        end else if (!latched_req && min_met) begin
          state_d = S_CLOSE;
          cnt_d   = '0;
        end
      end

      S_CLOSE: begin
        if (delay_done) begin
          state_d = S_COOL;
          cnt_d   = '0;
        end
      end

      S_COOL: begin
        if (cool_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          chan_d  = 3'b000;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        chan_d  = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chan_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
    end
  end

`ifdef IRRIGATION_VALVE_SEQ_TIMEOUT_EN
  // A lockout is released by seeing the request low at any clock edge; a
  // fresh timeout on the same edge takes precedence and re-arms it.
  always_comb begin
    lock_d  = (lock_q & req_vec) | (timeout_now ? chan_q : 3'b000);
    alarm_d = alarm_q | timeout_now;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q  <= 3'b000;
      alarm_q <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      alarm_q <= alarm_d;
    end
  end

  assign timeout_alarm = alarm_q;
`else
  assign timeout_alarm = 1'b0;
`endif

  // Outputs decode purely from registered state and the one-hot latch, so
  // at most one valve can be high and the pump only runs inside an open
  // window. Reset drops straight to IDLE, closing everything next cycle.
  assign valve_on        = (state_q == S_OPEN) || (state_q == S_RUN) ||
                           (state_q == S_CLOSE);
  assign sprinkler_valve = valve_on & chan_q[0];
  assign drip_valve      = valve_on & chan_q[1];
  assign specific_valve  = valve_on & chan_q[2];
  assign pump            = (state_q == S_RUN) && (chan_q != 3'b000);
  assign busy            = (state_q != S_IDLE);
  assign state_dbg       = state_q;

endmodule
